// File: rtl/alu_share_sequencer.sv
// alu_share_sequencer: round-robin sharing of one external combinational ALU.
// A winning request's operands are registered onto the ALU inputs, held for
// SETTLE cycles, and the sampled result is returned on a tagged response channel.
module alu_share_sequencer #(
  parameter int NREQ   = 4,
  parameter int W      = 8,
  parameter int OPW    = 4,
  parameter int SETTLE = 2,
  parameter int IDW    = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*W-1:0]   req_a,
  input  logic [NREQ*W-1:0]   req_b,
  input  logic [NREQ*OPW-1:0] req_op,
  input  logic [NREQ-1:0]     req_cin,
  output logic [W-1:0]        alu_a,
  output logic [W-1:0]        alu_b,
  output logic [OPW-1:0]      alu_op,
  output logic                alu_cin,
  input  logic [W-1:0]        alu_y,
  input  logic                alu_cout,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [W-1:0]        rsp_y,
  output logic                rsp_cout,
  output logic                busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]                   state;
  logic [IDW-1:0]               ptr;
  logic [3:0]                   cnt;
  logic                         gnt_any;
  logic [IDW-1:0]               gnt_id;
  logic [IDW-1:0]               ptr_nxt;
  logic [NREQ-1:0][W-1:0]       a_arr;
  logic [NREQ-1:0][W-1:0]       b_arr;
  logic [NREQ-1:0][OPW-1:0]     op_arr;

  // Flat request buses viewed as per-requester lanes
  assign a_arr  = req_a;
  assign b_arr  = req_b;
  assign op_arr = req_op;

  // Rotating-priority search: first valid requester at or above ptr, wrapping.
  // Scanning from the farthest offset down lets the nearest one win last.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_any = 1'b0;
    gnt_id  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = idx[IDW-1:0];
      end
    end
  end

  // Pointer moves just past the winner so it becomes lowest priority next round
  assign ptr_nxt = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);

  // Accept goes only to the winner, only in IDLE, never while reset is applied
  always_comb begin
    req_ready = '0;
    if (!rst && state == S_IDLE && gnt_any)
      req_ready[gnt_id] = 1'b1;
  end

  // Sequencer: grant/latch operands, hold for the settle window, return result
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ptr       <= '0;
      cnt       <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      alu_cin   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_y     <= '0;
      rsp_cout  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (gnt_any) begin
            alu_a   <= a_arr[gnt_id];
            alu_b   <= b_arr[gnt_id];
            alu_op  <= op_arr[gnt_id];
            alu_cin <= req_cin[gnt_id];
            rsp_id  <= gnt_id;
            ptr     <= ptr_nxt;
            cnt     <= 4'(SETTLE - 1);
            state   <= S_EXEC;
            busy    <= 1'b1;
          end
        end
        S_EXEC: begin
          // alu_* are untouched here: the ALU path is a multicycle path
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rsp_y     <= alu_y;
            rsp_cout  <= alu_cout;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end
        end
        S_RESP: begin
          // No grant in the handshake cycle; IDLE is re-entered first
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
            busy      <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Structural invariants
  a_onehot_ready: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
  a_rsp_state:    assert property (@(posedge clk) disable iff (rst) rsp_valid == (state == S_RESP));

endmodule

// File: tb/tb_alu_share_sequencer.sv
// Scoreboard bench for alu_share_sequencer with an XOR ALU stub.
module tb_alu_share_sequencer;
  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int OPW  = 4;
  localparam int IDW  = $clog2(NREQ);
  parameter  int SETTLE = 2;

  logic                clk;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*W-1:0]   req_a;
  logic [NREQ*W-1:0]   req_b;
  logic [NREQ*OPW-1:0] req_op;
  logic [NREQ-1:0]     req_cin;
  logic [W-1:0]        alu_a, alu_b, alu_y;
  logic [OPW-1:0]      alu_op;
  logic                alu_cin, alu_cout;
  logic                rsp_valid, rsp_ready, rsp_cout, busy;
  logic [IDW-1:0]      rsp_id;
  logic [W-1:0]        rsp_y;

  alu_share_sequencer #(.NREQ(NREQ), .W(W), .OPW(OPW), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_cin(req_cin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
    .alu_y(alu_y), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_y(rsp_y), .rsp_cout(rsp_cout), .busy(busy)
  );

  // ALU stub
  assign alu_y    = alu_a ^ alu_b;
  assign alu_cout = alu_cin;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int             id;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [OPW-1:0] op;
    logic           cin;
    int             gc;
  } exp_t;

  exp_t            sb[$];
  exp_t            cur;
  int              n_tests = 0;
  int              n_fail  = 0;
  logic [NREQ-1:0] pend = '0;
  logic [W-1:0]    pa[NREQ];
  logic [W-1:0]    pb[NREQ];
  logic [OPW-1:0]  pop[NREQ];
  logic            pcin[NREQ];
  int              mptr = 0;
  bit              op_active = 0;
  int              hs_cyc = -1;
  bit              rand_en = 0;
  int              gnt_taken = -1;
  int              rdy_pct = 100;
  bit              seen_first = 0;
  bit              late_flag = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, expv);
    end
  endtask

  task automatic new_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [OPW-1:0] op, input logic cin);
    pend[i] = 1'b1; pa[i] = a; pb[i] = b; pop[i] = op; pcin[i] = cin;
  endtask

  task automatic apply_inputs();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]          = pend[i];
      req_a[i*W +: W]       = pa[i];
      req_b[i*W +: W]       = pb[i];
      req_op[i*OPW +: OPW]  = pop[i];
      req_cin[i]            = pcin[i];
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_id"},    rsp_id, 0);
    check({tag, "_rsp_y"},     rsp_y, 0);
    check({tag, "_rsp_cout"},  rsp_cout, 0);
    check({tag, "_alu_a"},     alu_a, 0);
    check({tag, "_alu_b"},     alu_b, 0);
    check({tag, "_alu_op"},    alu_op, 0);
    check({tag, "_alu_cin"},   alu_cin, 0);
    check({tag, "_busy"},      busy, 0);
  endtask

  // Reference model: the shared unit is free once the previous response has
  // been accepted; a free unit grants the first pending requester from mptr.
  task automatic check_cycle();
    bit idle;
    int w;
    if (rst) begin
      check("ready_in_reset", req_ready, 0);
      hs_cyc    = cyc;
      op_active = 0;
      return;
    end
    idle = !op_active && (cyc > hs_cyc);
    check("busy", busy, !idle);
    if (op_active && cyc > cur.gc) begin
      check("alu_a_hold",   alu_a, cur.a);
      check("alu_b_hold",   alu_b, cur.b);
      check("alu_op_hold",  alu_op, cur.op);
      check("alu_cin_hold", alu_cin, cur.cin);
    end
    if (idle && pend != '0) begin
      w = -1;
      for (int k = 0; k < NREQ; k++)
        if (w < 0 && pend[(mptr + k) % NREQ]) w = (mptr + k) % NREQ;
      check("grant", req_ready, 32'(1) << w);
      cur.id = w; cur.a = pa[w]; cur.b = pb[w]; cur.op = pop[w]; cur.cin = pcin[w];
      cur.gc = cyc;
      sb.push_back(cur);
      op_active = 1;
      mptr      = (w + 1) % NREQ;
      gnt_taken = w;
    end else begin
      check("no_grant", req_ready, 0);
    end
  endtask

  // One cycle: drive just after the edge, check at the falling edge
  task automatic step();
    @(posedge clk); #1;
    if (gnt_taken >= 0) begin
      pend[gnt_taken] = 1'b0;
      gnt_taken = -1;
    end
    if (rand_en)
      for (int i = 0; i < NREQ; i++)
        if (!pend[i] && $urandom_range(2) == 0)
          new_req(i, W'($urandom), W'($urandom), OPW'($urandom), 1'($urandom));
    rsp_ready = ($urandom_range(99) < rdy_pct);
    apply_inputs();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while (k < 400 && !(sb.size() == 0 && pend == '0 && !op_active && gnt_taken < 0)) begin
      step();
      k++;
    end
    check({tag, "_drain_left"}, sb.size(), 0);
  endtask

  task automatic wait_grant();
    int k;
    k = 0;
    while (k < 100 && gnt_taken < 0) begin
      step();
      k++;
    end
    check("wait_grant_timeout", (gnt_taken >= 0), 1);
  endtask

  // Monitor: compares every presented response against the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (rsp_valid) begin
          if (sb.size() == 0) begin
            check("rsp_spurious", rsp_valid, 0);
          end else begin
            e = sb[0];
            if (!seen_first) begin
              check("rsp_latency", cyc - e.gc, SETTLE + 1);
              seen_first = 1;
            end
            check("rsp_id",   rsp_id, e.id);
            check("rsp_y",    rsp_y, e.a ^ e.b);
            check("rsp_cout", rsp_cout, e.cin);
            if (rsp_ready) begin
              void'(sb.pop_front());
              seen_first = 0;
              late_flag  = 0;
              op_active  = 0;
              hs_cyc     = cyc;
            end
          end
        end else if (sb.size() > 0 && !seen_first && !late_flag &&
                     (cyc - sb[0].gc) > SETTLE + 1) begin
          check("rsp_timeout", rsp_valid, 1);
          late_flag = 1;
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      pa[i] = '0; pb[i] = '0; pop[i] = '0; pcin[i] = 1'b0;
    end
    rst = 1'b1;
    rsp_ready = 1'b0;
    apply_inputs();
    repeat (3) step();
    check_zero("reset");
    rst = 1'b0;

    // Single request from requester 1: XOR stub gives 8'h33, cout 1
    new_req(1, 8'h3C, 8'h0F, 4'h5, 1'b1);
    drain("single");

    // Fairness: after a grant to 2, requesters 0 and 3 -> 3 then 0
    new_req(2, 8'h11, 8'h22, 4'h1, 1'b0);
    wait_grant();
    new_req(0, 8'hA0, 8'h0A, 4'h2, 1'b1);
    new_req(3, 8'h55, 8'hFF, 4'h3, 1'b0);
    drain("fair");

    // All four requesting together with rsp_ready high
    for (int i = 0; i < NREQ; i++) new_req(i, W'($urandom), W'($urandom), OPW'($urandom), 1'($urandom));
    drain("all4");

    // Backpressure: response held while requester 0 waits
    new_req(1, 8'hC3, 8'h3C, 4'h7, 1'b1);
    wait_grant();
    new_req(0, 8'h01, 8'h80, 4'h8, 1'b0);
    rdy_pct = 0;
    repeat (SETTLE + 6) step();
    rdy_pct = 100;
    drain("bp");

    // Randomized traffic with random backpressure
    rand_en = 1; rdy_pct = 70;
    repeat (2000) step();
    rand_en = 0; rdy_pct = 100;
    drain("random");

    // Reset one cycle after a grant: operation dropped, pointer back to 0
    new_req(2, 8'h77, 8'h07, 4'h9, 1'b1);
    wait_grant();
    @(posedge clk); #1;
    pend[gnt_taken] = 1'b0;
    gnt_taken = -1;
    rst = 1'b1;
    sb.delete();
    seen_first = 0; late_flag = 0;
    op_active = 0; mptr = 0;
    new_req(1, 8'h12, 8'h34, 4'hA, 1'b0);
    new_req(0, 8'h56, 8'h78, 4'hB, 1'b1);
    apply_inputs();
    @(negedge clk);
    check_cycle();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_zero("post_reset");
    check_cycle();
    drain("after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
